// File: rtl/dsp_mul_arbiter.sv
// dsp_mul_arbiter: NREQ requesters share one pipelined unsigned multiplier.
// A round-robin arbiter grants at most one requester per cycle. The operands
// and the requester id then pass through a LAT-stage pipeline that maps onto
// the operand and product registers of a single DSP multiplier.
// Build option: define DSP_MUL_ARBITER_PRIO0_EN to give requester 0 absolute
// priority; the remaining requesters are then arbitrated round-robin.
module dsp_mul_arbiter #(
   parameter int AW   = 8,
   parameter int BW   = 8,
   parameter int NREQ = 4,
   parameter int LAT  = 2,
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int PW  = AW + BW
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*AW-1:0] req_a,
   input  logic [NREQ*BW-1:0] req_b,
   output logic [NREQ-1:0]    req_ready,
   output logic               res_valid,
   output logic [IDW-1:0]     res_id,
   output logic [PW-1:0]      res_p,
   output logic               busy
);

   logic [IDW-1:0] ptr_q;
   logic [IDW-1:0] ptr_d;
   logic [NREQ-1:0] gnt_s;
   logic [IDW-1:0] gnt_idx_s;
   logic           gnt_any_s;
   logic [IDW-1:0] rr_idx_s;
   logic           rr_any_s;
   logic [AW-1:0]  a_sel_s;
   logic [BW-1:0]  b_sel_s;
   logic [LAT-1:0] v_q;
   logic [IDW-1:0] id_q [LAT];
   logic [PW-1:0]  p_q;

   // Round-robin search from ptr; scanned backwards so the first valid index wins.
   always_comb begin
      rr_idx_s = '0;
      rr_any_s = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         int idx;
         idx      = (int'(ptr_q) + k) % NREQ;
         rr_idx_s = req_valid[idx] ? IDW'(idx) : rr_idx_s;
         rr_any_s = rr_any_s | req_valid[idx];
      end
   end

   // Final grant: priority override (optional), reset gating, one-hot decode.
   always_comb begin
      gnt_s     = '0;
      gnt_idx_s = '0;
      gnt_any_s = 1'b0;
      if (rstn) begin
`ifdef DSP_MUL_ARBITER_PRIO0_EN
         if (req_valid[0]) begin
            gnt_idx_s = '0;
            gnt_any_s = 1'b1;
         end else begin
            gnt_idx_s = rr_idx_s;
            gnt_any_s = rr_any_s;
         end
`else
         gnt_idx_s = rr_idx_s;
         gnt_any_s = rr_any_s;
`endif
      end else begin
         gnt_any_s = 1'b0;
      end
      if (gnt_any_s) begin
         gnt_s[gnt_idx_s] = 1'b1;
      end else begin
         gnt_s = '0;
      end
   end

   assign req_ready = gnt_s;

   // Next pointer: one past the granted index, held when nothing is granted.
   always_comb begin
      ptr_d = ptr_q;
      if (gnt_any_s) begin
`ifdef DSP_MUL_ARBITER_PRIO0_EN
         if (gnt_idx_s == '0) begin
            ptr_d = ptr_q;
         end else begin
            ptr_d = IDW'((int'(gnt_idx_s) + 1) % NREQ);
         end
`else
         ptr_d = IDW'((int'(gnt_idx_s) + 1) % NREQ);
`endif
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Operand mux: one-hot grant selects the winning requester's operands.
   always_comb begin
      a_sel_s = '0;
      b_sel_s = '0;
      for (int i = 0; i < NREQ; i++) begin
         a_sel_s = a_sel_s | (req_a[i*AW +: AW] & {AW{gnt_s[i]}});
         b_sel_s = b_sel_s | (req_b[i*BW +: BW] & {BW{gnt_s[i]}});
      end
   end

   // Control state: pointer and per-stage valid bits, cleared by reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         ptr_q <= '0;
         v_q   <= '0;
      end else begin
         ptr_q  <= ptr_d;
         v_q[0] <= gnt_any_s;
         for (int s = 1; s < LAT; s++) begin
            v_q[s] <= v_q[s-1];
         end
      end
   end

   // Id pipeline travels alongside the valid bits; no reset needed.
   always_ff @(posedge clk) begin
      id_q[0] <= gnt_idx_s;
      for (int s = 1; s < LAT; s++) begin
         id_q[s] <= id_q[s-1];
      end
   end

   if (LAT == 1) begin : g_lat1
      // Single stage: multiply straight into the product register.
      always_ff @(posedge clk) begin
         p_q <= PW'(a_sel_s) * PW'(b_sel_s);
      end
   end else begin : g_latn
      logic [AW-1:0] a_q;
      logic [BW-1:0] b_q;
      // Operand input registers of the multiplier.
      always_ff @(posedge clk) begin
         a_q <= a_sel_s;
         b_q <= b_sel_s;
      end
      if (LAT == 2) begin : g_lat2
         // Product register directly after the operand registers.
         always_ff @(posedge clk) begin
            p_q <= PW'(a_q) * PW'(b_q);
         end
      end else begin : g_lat3
         logic [PW-1:0] m_q;
         // Multiplier internal register followed by the output register.
         always_ff @(posedge clk) begin
            m_q <= PW'(a_q) * PW'(b_q);
            p_q <= m_q;
         end
      end
   end

   assign res_valid = v_q[LAT-1];
   assign res_id    = id_q[LAT-1];
   assign res_p     = p_q;
   assign busy      = |v_q;

endmodule

// File: tb/tb_dsp_mul_arbiter.sv
// Directed bench for dsp_mul_arbiter (NREQ=4, LAT=2, AW=BW=8).
// Define DSP_MUL_ARBITER_PRIO0_EN for both files to exercise the priority build.
module tb_dsp_mul_arbiter;

   logic        clk;
   logic        rstn;
   logic [3:0]  req_valid;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [3:0]  req_ready;
   logic        res_valid;
   logic [1:0]  res_id;
   logic [15:0] res_p;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   dsp_mul_arbiter #(.AW(8), .BW(8), .NREQ(4), .LAT(2)) dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .res_valid(res_valid), .res_id(res_id), .res_p(res_p),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [3:0] exp_g;
      rstn = 1'b0; req_valid = 4'b0000; req_a = 32'd0; req_b = 32'd0;
      repeat (3) step();

      // Reset state; grants suppressed while in reset.
      req_valid = 4'b1111; #2;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      req_valid = 4'b0000; rstn = 1'b1;
      step();

      // Single request 3*5 from requester 0.
      req_a[7:0] = 8'd3; req_b[7:0] = 8'd5; req_valid = 4'b0001; #2;
      chk("single_ready", 32'(req_ready), 32'h1);
      chk("single_busy0", 32'(busy), 32'd0);
      step(); req_valid = 4'b0000; #2;
      chk("single_busy1", 32'(busy), 32'd1);
      chk("single_nores", 32'(res_valid), 32'd0);
      step(); #2;
      chk("single_valid", 32'(res_valid), 32'd1);
      chk("single_id", 32'(res_id), 32'd0);
      chk("single_p", 32'(res_p), 32'd15);
      chk("single_busy2", 32'(busy), 32'd1);
      step(); #2;
      chk("single_done", 32'(res_valid), 32'd0);
      chk("single_idle", 32'(busy), 32'd0);
      step();

      // Max operands from requester 1.
      req_a[15:8] = 8'd255; req_b[15:8] = 8'd255; req_valid = 4'b0010; #2;
      chk("max_ready", 32'(req_ready), 32'h2);
      step(); req_valid = 4'b0000;
      step(); #2;
      chk("max_valid", 32'(res_valid), 32'd1);
      chk("max_id", 32'(res_id), 32'd1);
      chk("max_p", 32'(res_p), 32'hFE01);
      step();

`ifdef DSP_MUL_ARBITER_PRIO0_EN
      rstn = 1'b0; step(); rstn = 1'b1;
      req_valid = 4'b1111;
      for (int c = 0; c < 4; c++) begin
         #2; chk("prio_all", 32'(req_ready), 32'h1);
         step();
      end
      req_valid = 4'b1110;
      for (int c = 0; c < 4; c++) begin
         case (c)
            0: exp_g = 4'b0010;
            1: exp_g = 4'b0100;
            2: exp_g = 4'b1000;
            default: exp_g = 4'b0010;
         endcase
         #2; chk("prio_rr", 32'(req_ready), 32'(exp_g));
         step();
      end
      req_valid = 4'b0000;
      repeat (3) step();
      #2; chk("prio_idle", 32'(busy), 32'd0);
`else
      // Reset mid-flight: ptr is 2 here, so 0001 still grants requester 0.
      req_a[7:0] = 8'd7; req_b[7:0] = 8'd9; req_valid = 4'b0001; #2;
      chk("mid_ready", 32'(req_ready), 32'h1);
      step(); req_valid = 4'b0000; rstn = 1'b0; #2;
      chk("mid_busy_pre", 32'(busy), 32'd1);
      step(); rstn = 1'b1; #2;
      chk("mid_nores", 32'(res_valid), 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      req_valid = 4'b1111; #2;
      chk("mid_ptr0", 32'(req_ready), 32'h1);
      req_valid = 4'b0000;
      for (int c = 0; c < 3; c++) begin
         step(); #2;
         chk("mid_quiet", 32'(res_valid), 32'd0);
      end

      // All-valid fairness from reset.
      rstn = 1'b0; step(); rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_a[i*8 +: 8] = 8'(i + 2);
         req_b[i*8 +: 8] = 8'(i + 10);
      end
      req_valid = 4'b1111;
      for (int c = 0; c < 10; c++) begin
         if (c == 8) req_valid = 4'b0000;
         else req_valid = req_valid;
         #2;
         if (c < 8) chk("fair_grant", 32'(req_ready), 32'(1 << (c % 4)));
         else chk("fair_nogrant", 32'(req_ready), 32'd0);
         if (c >= 2) begin
            chk("fair_valid", 32'(res_valid), 32'd1);
            chk("fair_id", 32'(res_id), 32'((c - 2) % 4));
            chk("fair_p", 32'(res_p), 32'((((c - 2) % 4) + 2) * (((c - 2) % 4) + 10)));
         end else begin
            chk("fair_early", 32'(res_valid), 32'd0);
         end
         step();
      end
      #2;
      chk("fair_end", 32'(res_valid), 32'd0);
      chk("fair_idle", 32'(busy), 32'd0);

      // Wrap and skip: move ptr to 3, then 0101 grants 0 then 2.
      req_valid = 4'b0100; #2;
      chk("wrap_pre", 32'(req_ready), 32'h4);
      step(); req_valid = 4'b0101; #2;
      chk("wrap_g0", 32'(req_ready), 32'h1);
      step(); #2;
      chk("wrap_g2", 32'(req_ready), 32'h4);
      step(); req_valid = 4'b0000; #2;
      chk("wrap_none", 32'(req_ready), 32'd0);
      step(); step(); req_valid = 4'b1111; #2;
      chk("wrap_hold", 32'(req_ready), 32'h8);
      step(); req_valid = 4'b0000;
      repeat (3) step();
      #2; chk("wrap_idle", 32'(busy), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dsp_mul_arbiter.md
DSP_MUL_ARBITER -- requirements
Module: dsp_mul_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, the operand A width.
REQ-002 SHALL have parameter BW, default 8, the operand B width.
REQ-003 SHALL have parameter NREQ, default 4, the requester count; legal range is 2..8.
REQ-004 SHALL have parameter LAT, default 2, the accept-to-result latency in cycles; legal range is 1..3.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port req_valid, input, NREQ bits: per-requester operand-valid.
REQ-008 SHALL have port req_a, input, NREQ*AW bits: operand A, requester i in slice [i*AW +: AW].
REQ-009 SHALL have port req_b, input, NREQ*BW bits: operand B, requester i in slice [i*BW +: BW].
REQ-010 SHALL have port req_ready, output, NREQ bits: one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-011 SHALL have port res_valid, output, 1 bit: the result is valid this cycle.
REQ-012 SHALL have port res_id, output, clog2(NREQ) bits: the index of the requester that owns the result.
REQ-013 SHALL have port res_p, output, AW+BW bits: the unsigned product A*B.
REQ-014 SHALL have port busy, output, 1 bit: high while any accepted operation has not yet produced its result.

Function
REQ-015 req_ready SHALL be combinational from req_valid and the priority pointer, with at most one bit high per cycle.
REQ-016 req_ready SHALL be all-zero when req_valid is all-zero.
REQ-017 Arbitration SHALL be round-robin: the search starts at index ptr and wraps from NREQ-1 to 0; the first valid index is granted.
REQ-018 On a grant to index g, ptr SHALL become (g+1) mod NREQ on the next edge; with no grant, ptr SHALL hold.
REQ-019 One operation SHALL be accepted per cycle; the pipeline never stalls and res_* has no backpressure.
REQ-020 The granted operands and id SHALL enter an LAT-stage pipeline with a valid bit per stage; the stages map to the operand and product registers of one DSP multiplier.
REQ-021 res_valid, res_id and res_p SHALL appear exactly LAT cycles after the accepting edge, all registered.
REQ-022 res_p SHALL be the full-width unsigned product, with no truncation or overflow.
REQ-023 Results SHALL emerge in acceptance order; back-to-back accepts SHALL give back-to-back results.
REQ-024 res_id and res_p SHALL be don't-care when res_valid is low, and the bench SHALL NOT check them then.
REQ-025 busy SHALL be the OR of all pipeline-stage valid bits.
REQ-026 A requester that drops req_valid before being granted SHALL NOT be accepted; no request is latched early.

Reset
REQ-027 With rstn low at a clk edge, all stage valid bits, res_valid and busy SHALL clear to 0 and ptr SHALL become 0.
REQ-028 req_ready SHALL be all-zero in any cycle where rstn is low.
REQ-029 Reset mid-operation SHALL discard every in-flight operation; no res_valid SHALL appear for those operations after reset releases.
REQ-030 The data and id pipeline registers SHALL need no reset.

Configuration
REQ-031 Macro DSP_MUL_ARBITER_PRIO0_EN SHALL select the priority scheme.
REQ-032 With DSP_MUL_ARBITER_PRIO0_EN defined, requester 0 SHALL win whenever req_valid[0] is high, and ptr SHALL NOT advance on a requester-0 grant.
REQ-033 With DSP_MUL_ARBITER_PRIO0_EN defined, requesters 1..NREQ-1 SHALL be arbitrated round-robin among themselves when req_valid[0] is low.
REQ-034 With DSP_MUL_ARBITER_PRIO0_EN undefined, pure round-robin per REQ-017 SHALL apply to all requesters.

Verification
REQ-035 Single request: NREQ=4, LAT=2, req_valid=0001, A=3, B=5 for one cycle -> req_ready=0001 that cycle; 2 cycles later res_valid=1, res_id=0, res_p=15; busy=1 for exactly 2 cycles.
REQ-036 All-valid fairness: req_valid=1111 held for 8 cycles from reset -> grants 0,1,2,3,0,1,2,3; results carry ids in the same order, one per cycle, starting at cycle 2.
REQ-037 Wrap and skip: ptr=3 with req_valid=0101 -> grant 0 and then 2; req_valid=0000 -> no grant and ptr unchanged.
REQ-038 Max operands: A=255, B=255 -> res_p=65025 (0xFE01).
REQ-039 Reset mid-flight: accept in cycle t, rstn low in cycle t+1 -> no res_valid in cycle t+2; busy=0 and ptr=0 after reset.
REQ-040 PRIO0 build, with req_valid=1111 held: requester 0 granted every cycle, and 1..3 never granted. With req_valid=1110: grants 1,2,3,1.
